// File: rtl/input_debounce3_pkg.sv
// ----------------------------------------------------------------------------
// input_debounce3_pkg
// Shared helper for the input debounce block: derives the counter width from
// the debounce length so that every instance sizes its counter the same way.
// ----------------------------------------------------------------------------
package input_debounce3_pkg;

    // Counter must hold 0..n-1. $clog2(1) is 0, so clamp to at least one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : input_debounce3_pkg

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One debounce lane: 2-flop synchroniser, qualification counter, registered
// debounced level and one-cycle rise/fall event pulses.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears all state
//   din    in   raw asynchronous level
//   dout   out  debounced, clock-synchronous level
//   rise   out  one-cycle pulse coincident with dout going 0->1
//   fall   out  one-cycle pulse coincident with dout going 1->0
// ----------------------------------------------------------------------------
module debounce_channel
    import input_debounce3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchroniser: only s2 is trusted by the logic below.
    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge value of its source; blocking here would collapse s1/s2 into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Qualification: s2 must differ from the current stable level for
    // DEBOUNCE_CYCLES consecutive edges. Any return to the stable level
    // restarts the count, so short excursions never reach the output.
    // The pulses are registered on the same edge that flips stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
                rise   <= s2;
                fall   <= ~s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign dout = stable;

endmodule : debounce_channel

// File: rtl/input_debounce3.sv
// ----------------------------------------------------------------------------
// input_debounce3
// Conditions three raw switch/button levels into clean synchronous levels
// feeding the downstream three-input AND stage, plus per-channel rise/fall
// event pulses for downstream counters. Channels are fully independent.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   raw    in   [2:0] raw levels; bit0 -> a, bit1 -> b, bit2 -> c
//   a      out  debounced raw[0]
//   b      out  debounced raw[1]
//   c      out  debounced raw[2]
//   rise   out  [2:0] one-cycle 0->1 pulses, bit i for channel i
//   fall   out  [2:0] one-cycle 1->0 pulses, bit i for channel i
// ----------------------------------------------------------------------------
module input_debounce3 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] raw,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] rise,
    output logic [2:0] fall
);

    logic [2:0] dout;

    for (genvar i = 0; i < 3; i++) begin : gen_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (raw[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign a = dout[0];
    assign b = dout[1];
    assign c = dout[2];

endmodule : input_debounce3

// File: tb/tb_input_debounce3.sv
// ----------------------------------------------------------------------------
// tb_input_debounce3
// Directed stimulus with hand-computed expected pulse events. The stimulus
// pushes each expected event (edge number, rise, fall, levels) into a queue;
// the monitor pops and compares whenever the DUT shows a rise/fall pulse.
// ----------------------------------------------------------------------------
module tb_input_debounce3;

    localparam int DC  = 4;
    localparam int LAT = DC + 1;  // edges from first sample to output change

    typedef struct {
        int       edge_no;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] lvl;   // {c, b, a}
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] raw;
    logic       a, b, c;
    logic [2:0] rise, fall;

    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    evt_t exp_q[$];

    input_debounce3 #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .a     (a),
        .b     (b),
        .c     (c),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic push(input int e, input logic [2:0] r, input logic [2:0] f, input logic [2:0] l);
        evt_t ev;
        ev.edge_no = e;
        ev.rise    = r;
        ev.fall    = f;
        ev.lvl     = l;
        exp_q.push_back(ev);
    endtask

    // Monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        if ((rise | fall) != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {26'd0, rise, fall}, 32'd0);
            end else begin
                evt_t ev;
                ev = exp_q.pop_front();
                check("evt_edge", edge_cnt, ev.edge_no);
                check("evt_rise", {29'd0, rise}, {29'd0, ev.rise});
                check("evt_fall", {29'd0, fall}, {29'd0, ev.fall});
                check("evt_lvl",  {29'd0, c, b, a}, {29'd0, ev.lvl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int r;

        // Reset then idle.
        raw   = 3'b000;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_out", {23'd0, a, b, c, rise, fall}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_out", {23'd0, a, b, c, rise, fall}, 32'd0);
        end

        // Clean step on raw[0].
        k = edge_cnt + 1;
        raw[0] = 1'b1;
        push(k + LAT, 3'b001, 3'b000, 3'b001);
        wait_edge(k + LAT - 1);
        check("step_a_early", {31'd0, a}, 32'd0);
        wait_edge(k + LAT);
        check("step_a", {31'd0, a}, 32'd1);
        check("step_rise", {29'd0, rise}, 32'd1);
        wait_edge(k + LAT + 1);
        check("step_rise_clr", {29'd0, rise}, 32'd0);
        check("step_a_hold", {31'd0, a}, 32'd1);

        // Glitch of 3 cycles on raw[1] is rejected.
        repeat (3) @(negedge clk);
        k = edge_cnt + 1;
        raw[1] = 1'b1;
        wait_edge(k + 2);
        raw[1] = 1'b0;
        wait_edge(k + 12);
        check("glitch_b", {31'd0, b}, 32'd0);

        // A 4-cycle pulse qualifies, then its release qualifies too.
        k = edge_cnt + 1;
        raw[1] = 1'b1;
        push(k + LAT, 3'b010, 3'b000, 3'b011);
        wait_edge(k + 3);
        raw[1] = 1'b0;
        push(k + 4 + LAT, 3'b000, 3'b010, 3'b001);
        wait_edge(k + LAT);
        check("pulse4_b", {31'd0, b}, 32'd1);
        wait_edge(k + 12);
        check("pulse4_b_back", {31'd0, b}, 32'd0);

        // Bounce train on raw[2], then held high.
        for (int i = 0; i < 10; i++) begin
            raw[2] = (i % 2 == 0);
            wait_edge(edge_cnt + 2);
        end
        k = edge_cnt + 1;
        raw[2] = 1'b1;
        push(k + LAT, 3'b100, 3'b000, 3'b101);
        wait_edge(k + LAT - 1);
        check("bounce_c_early", {31'd0, c}, 32'd0);
        wait_edge(k + LAT);
        check("bounce_c", {31'd0, c}, 32'd1);
        wait_edge(k + 10);

        // Simultaneous: clear a and c, then all rise together, then all fall.
        k = edge_cnt + 1;
        raw = 3'b000;
        push(k + LAT, 3'b000, 3'b101, 3'b000);
        wait_edge(k + 8);
        k = edge_cnt + 1;
        raw = 3'b111;
        push(k + LAT, 3'b111, 3'b000, 3'b111);
        wait_edge(k + LAT);
        check("and_high", {31'd0, a & b & c}, 32'd1);
        wait_edge(k + 8);
        k = edge_cnt + 1;
        raw = 3'b000;
        push(k + LAT, 3'b000, 3'b111, 3'b000);
        wait_edge(k + LAT);
        check("and_low", {31'd0, a & b & c}, 32'd0);
        wait_edge(k + 8);

        // Async reset mid-count: b is high, a is counting when reset hits.
        k = edge_cnt + 1;
        raw = 3'b010;
        push(k + LAT, 3'b010, 3'b000, 3'b010);
        wait_edge(k + 8);
        k = edge_cnt + 1;
        raw = 3'b011;
        wait_edge(k + 3);
        rst_n = 1'b0;
        #1;
        check("async_clr", {23'd0, a, b, c, rise, fall}, 32'd0);
        repeat (2) @(negedge clk);
        check("async_hold", {23'd0, a, b, c, rise, fall}, 32'd0);
        rst_n = 1'b1;
        r = edge_cnt + 1;
        push(r + LAT, 3'b011, 3'b000, 3'b011);
        wait_edge(r + LAT - 1);
        check("requal_a_early", {31'd0, a}, 32'd0);
        wait_edge(r + LAT);
        check("requal_ab", {30'd0, b, a}, 32'd3);
        wait_edge(r + 10);

        check("events_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_debounce3
